// File: rtl/l2_cache_pkg.sv
// Shared widths, FSM encodings and helpers for the L2 line cache.
package l2_cache_pkg;
  localparam int LINE_W  = 128;
  localparam int ADDR_W  = 28;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE       = 2'd0;
  localparam logic [STATE_W-1:0] S_WRITE_BACK = 2'd1;
  localparam logic [STATE_W-1:0] S_ALLOCATE   = 2'd2;
  localparam logic [STATE_W-1:0] S_RESPOND    = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/l2_tag_data_array.sv
// Direct-mapped tag/data/valid/dirty store: combinational read, synchronous single-port write.
module l2_tag_data_array
  import l2_cache_pkg::*;
#(
  parameter int NUM_OF_SET = 64,
  parameter int SET_OFFSET = 6,
  parameter int TAG_W      = ADDR_W - SET_OFFSET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SET_OFFSET-1:0] idx,
  input  logic                  we,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_W-1:0]     wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_dirty
);
  logic [NUM_OF_SET-1:0][TAG_W-1:0]  tag_q;
  logic [NUM_OF_SET-1:0][LINE_W-1:0] data_q;
  logic [NUM_OF_SET-1:0]             valid_q;
  logic [NUM_OF_SET-1:0]             dirty_q;

  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // Only the state bits need clearing; tag/data are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= wr_valid;
      dirty_q[idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_data;
    end
  end
endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 line cache between L1 and main memory.
// Optional hit/miss statistics are built when L2_STATS_EN is defined.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int NUM_OF_SET = 64,
  parameter int SET_OFFSET = 6
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [LINE_W-1:0] l1_wdata,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int TAG_W = ADDR_W - SET_OFFSET;

  logic [STATE_W-1:0]    state, state_n;
  logic                  cool;
  logic                  req_wr;
  logic [SET_OFFSET-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_data;
  logic                  rd_valid, rd_dirty;
  logic                  we, wr_valid, wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic [LINE_W-1:0]     wr_data;
  logic                  accept, hit, is_wr;

  assign idx    = l1_addr[SET_OFFSET-1:0];
  assign tag    = l1_addr[ADDR_W-1:SET_OFFSET];
  assign hit    = rd_valid && (rd_tag == tag);
  assign is_wr  = !l1_read && l1_write;
  // The L1 strobe is still high in the IDLE cycle right after RESPOND.
  assign accept = (state == S_IDLE) && !cool && (l1_read || l1_write);

  l2_tag_data_array #(
    .NUM_OF_SET(NUM_OF_SET),
    .SET_OFFSET(SET_OFFSET),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (proc_reset),
    .idx     (idx),
    .we      (we),
    .wr_tag  (wr_tag),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty)
  );

  always_comb begin
    state_n  = state;
    we       = 1'b0;
    wr_tag   = tag;
    wr_data  = l1_wdata;
    wr_valid = 1'b1;
    wr_dirty = 1'b1;
    case (state)
      S_IDLE: if (accept) begin
        if (hit) begin
          we      = is_wr;
          state_n = S_RESPOND;
        end else if (rd_valid && rd_dirty) begin
          state_n = S_WRITE_BACK;
        end else if (is_wr) begin
          we      = 1'b1;
          state_n = S_RESPOND;
        end else begin
          state_n = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: if (mem_ready) begin
        we = 1'b1;
        // A pending write replaces the line outright; a read just cleans the victim.
        if (req_wr) begin
          state_n = S_RESPOND;
        end else begin
          wr_tag   = rd_tag;
          wr_data  = rd_data;
          wr_dirty = 1'b0;
          state_n  = S_ALLOCATE;
        end
      end
      S_ALLOCATE: if (mem_ready) begin
        we       = 1'b1;
        wr_data  = mem_rdata;
        wr_dirty = 1'b0;
        state_n  = S_RESPOND;
      end
      default: state_n = S_IDLE;
    endcase
    if (proc_reset) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state    <= S_IDLE;
      cool     <= 1'b0;
      req_wr   <= 1'b0;
      l1_rdata <= '0;
    end else begin
      state <= state_n;
      cool  <= (state == S_RESPOND);
      if (accept) req_wr <= is_wr;
      if (accept && hit && !is_wr) l1_rdata <= rd_data;
      else if (state == S_ALLOCATE && mem_ready) l1_rdata <= mem_rdata;
    end
  end

  assign l1_ready  = (state == S_RESPOND);
  assign mem_write = (state == S_WRITE_BACK);
  assign mem_read  = (state == S_ALLOCATE);
  assign mem_addr  = mem_write ? {rd_tag, idx} : (mem_read ? l1_addr : '0);
  assign mem_wdata = mem_write ? rd_data : '0;

`ifdef L2_STATS_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (accept) begin
      if (hit) hit_q <= sat_inc(hit_q);
      else     miss_q <= sat_inc(miss_q);
    end
  end
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache with a small latency-programmable memory responder.
module tb_l2_cache;
  logic         clk = 1'b0;
  logic         proc_reset, l1_read, l1_write, l1_ready;
  logic [27:0]  l1_addr, mem_addr;
  logic [127:0] l1_wdata, l1_rdata, mem_wdata, mem_rdata;
  logic         mem_read, mem_write, mem_ready;
  logic [31:0]  hit_count, miss_count;

  int checks = 0, errors = 0;
  int n_mrd, n_mwr, n_rdy, lat_cyc, both, mrd_cyc, mwr_cyc, extra_mem;
  logic [27:0]  mrd_addr, mwr_addr;
  logic [127:0] mwr_data, rdata_rdy, rdata_next;

`ifdef L2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  l2_cache dut (
    .clk(clk), .proc_reset(proc_reset), .l1_read(l1_read), .l1_write(l1_write),
    .l1_addr(l1_addr), .l1_wdata(l1_wdata), .l1_rdata(l1_rdata), .l1_ready(l1_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one L1 request and act as memory, answering each mem strobe after lat waiting cycles.
  task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wd, input int lat, input logic [127:0] rdat);
    int wait_n = 0;
    l1_read = rd; l1_write = wr; l1_addr = addr; l1_wdata = wd;
    n_mrd = 0; n_mwr = 0; n_rdy = 0; lat_cyc = -1; mrd_cyc = -1; mwr_cyc = -1; extra_mem = 0;
    for (int c = 1; c <= 60 && lat_cyc < 0; c++) begin
      tick();
      mem_ready = 1'b0;
      if (mem_read && mem_write) both++;
      if (mem_read || mem_write) begin
        if (wait_n == lat) begin
          mem_ready = 1'b1; mem_rdata = rdat; wait_n = 0;
          if (mem_read) begin n_mrd++; mrd_addr = mem_addr; mrd_cyc = c; end
          else begin n_mwr++; mwr_addr = mem_addr; mwr_data = mem_wdata; mwr_cyc = c; end
        end else wait_n++;
      end
      if (l1_ready) begin n_rdy++; lat_cyc = c; rdata_rdy = l1_rdata; end
    end
    l1_read = 1'b0; l1_write = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) rdata_next = l1_rdata;
      if (l1_ready) n_rdy++;
      if (mem_read || mem_write) extra_mem++;
    end
  endtask

  initial begin
    logic [127:0] pa5, pc3;
    int rdy_after_rst;
    pa5 = {16{8'hA5}};
    pc3 = {16{8'hC3}};
    both = 0;
    proc_reset = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    check("rst_ready", {127'd0, l1_ready}, 128'd0);
    check("rst_rdata", l1_rdata, 128'd0);
    check("rst_mem_rw", {126'd0, mem_read, mem_write}, 128'd0);
    check("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    check("rst_counts", {64'd0, hit_count, miss_count}, 128'd0);
    proc_reset = 1'b0;
    tick();

    // Cold read miss, memory answers after 3 waiting cycles
    do_req(1'b1, 1'b0, 28'h0000040, '0, 3, pa5);
    check("miss_mrd_n", n_mrd, 1);
    check("miss_mrd_addr", {100'd0, mrd_addr}, 128'h40);
    check("miss_mwr_n", n_mwr, 0);
    check("miss_ready_n", n_rdy, 1);
    check("miss_latency", lat_cyc, 5);
    check("miss_rdata", rdata_rdy, pa5);
    check("miss_rdata_hold", rdata_next, pa5);
    check("miss_cnt1", {96'd0, miss_count}, STATS ? 128'd1 : 128'd0);

    // Read hit: ready next cycle, no memory traffic
    do_req(1'b1, 1'b0, 28'h0000040, '0, 0, '0);
    check("hit_latency", lat_cyc, 1);
    check("hit_mem", n_mrd + n_mwr + extra_mem, 0);
    check("hit_rdata", rdata_rdy, pa5);
    check("hit_cnt1", {96'd0, hit_count}, STATS ? 128'd1 : 128'd0);

    // Write miss over a clean victim: allocate without fetching; l1_rdata keeps last read
    do_req(1'b0, 1'b1, 28'h0000080, 128'h1234, 0, '0);
    check("wmiss_latency", lat_cyc, 1);
    check("wmiss_mem", n_mrd + n_mwr, 0);
    check("wmiss_rdata_kept", rdata_rdy, pa5);
    check("wmiss_cnt", {96'd0, miss_count}, STATS ? 128'd2 : 128'd0);

    // Read miss on same index evicts the dirty line first
    do_req(1'b1, 1'b0, 28'h00000C0, '0, 2, pc3);
    check("evict_mwr_n", n_mwr, 1);
    check("evict_mwr_addr", {100'd0, mwr_addr}, 128'h80);
    check("evict_mwr_data", mwr_data, 128'h1234);
    check("evict_mrd_n", n_mrd, 1);
    check("evict_mrd_addr", {100'd0, mrd_addr}, 128'hC0);
    check("evict_order", {127'd0, mwr_cyc < mrd_cyc}, 128'd1);
    check("evict_ready_n", n_rdy, 1);
    check("evict_rdata", rdata_rdy, pc3);

    // Read and write together: read wins, line untouched
    do_req(1'b1, 1'b1, 28'h00000C0, 128'hDEAD, 0, '0);
    check("rw_latency", lat_cyc, 1);
    check("rw_rdata", rdata_rdy, pc3);
    do_req(1'b1, 1'b0, 28'h00000C0, '0, 0, '0);
    check("rw_line_kept", rdata_rdy, pc3);
    check("rw_no_mem", n_mrd + n_mwr + extra_mem, 0);
    check("rw_hit_cnt", {96'd0, hit_count}, STATS ? 128'd3 : 128'd0);

    // Reset while allocating: no response, no install
    l1_read = 1'b1; l1_addr = 28'h0000100;
    tick();
    check("abort_in_alloc", {126'd0, mem_read, mem_write}, 128'd2);
    check("abort_mem_addr", {100'd0, mem_addr}, 128'h100);
    tick();
    proc_reset = 1'b1; mem_ready = 1'b1; mem_rdata = 128'hBAD;
    tick();
    check("abort_ready", {127'd0, l1_ready}, 128'd0);
    check("abort_rdata", l1_rdata, 128'd0);
    proc_reset = 1'b0; mem_ready = 1'b0; l1_read = 1'b0;
    rdy_after_rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (l1_ready || mem_read || mem_write) rdy_after_rst++;
    end
    check("abort_quiet", rdy_after_rst, 0);
    do_req(1'b1, 1'b0, 28'h0000100, '0, 1, 128'h77);
    check("abort_remiss", n_mrd, 1);
    check("abort_remiss_data", rdata_rdy, 128'h77);
    check("abort_counts", {64'd0, hit_count, miss_count}, STATS ? 128'd1 : 128'd0);

    check("mem_rw_overlap", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_cache.md
L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 SHALL have parameter NUM_OF_SET, default 64, meaning direct-mapped line count (power of 2); SET_OFFSET, default 6, meaning log2(NUM_OF_SET).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port proc_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports l1_read / l1_write  input  1 each  L1 request strobes, held until l1_ready seen.
REQ-005 SHALL have port l1_addr  input  28  line address; l1_wdata  input  128  write line.
REQ-006 SHALL have port l1_rdata  output  128  read line; l1_ready  output  1  one-cycle completion pulse.
REQ-007 SHALL have ports mem_read / mem_write  output  1 each; mem_addr  output  28; mem_wdata  output  128.
REQ-008 SHALL have ports mem_rdata  input  128; mem_ready  input  1  main-memory completion pulse.
REQ-009 SHALL have ports hit_count / miss_count  output  32 each  statistics (see Configuration).

Function
REQ-010 SHALL be the responder of the L1 line protocol: direct-mapped, write-back, index l1_addr[SET_OFFSET-1:0], tag l1_addr[27:SET_OFFSET].
REQ-011 SHALL use states IDLE, WRITE_BACK, ALLOCATE, RESPOND; every transition on clk edge.
REQ-012 IDLE, request present, hit: -> RESPOND; read loads line into l1_rdata, write stores l1_wdata and sets dirty.
REQ-013 IDLE, miss, victim valid and dirty: -> WRITE_BACK; mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim line, held until mem_ready.
REQ-014 IDLE, miss, victim clean/invalid: read -> ALLOCATE; write -> RESPOND, line overwritten with l1_wdata, valid=1, dirty=1 (full-line write, no fetch).
REQ-015 WRITE_BACK on mem_ready: victim dirty cleared; then same rule as REQ-014.
REQ-016 ALLOCATE: mem_read=1, mem_addr=l1_addr until mem_ready; in that cycle install mem_rdata, valid=1, dirty=0, l1_rdata=mem_rdata, -> RESPOND.
REQ-017 RESPOND: l1_ready=1 exactly one cycle, -> IDLE; no new request accepted in RESPOND or the first IDLE cycle after it (L1 strobe still high that cycle).
REQ-018 Hit latency SHALL be request at cycle t -> l1_ready at t+1.
REQ-019 l1_rdata SHALL remain stable from the l1_ready cycle until the next read response (L1 samples it one cycle after ready).
REQ-020 l1_read and l1_write simultaneously: read SHALL take priority, write ignored.
REQ-021 mem_read and mem_write SHALL never be asserted together; both 0 outside WRITE_BACK/ALLOCATE.
REQ-022 mem_ready outside WRITE_BACK/ALLOCATE SHALL be ignored.

Reset
REQ-023 proc_reset SHALL force IDLE, all valid/dirty=0, l1_ready=0, l1_rdata=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, counters=0.
REQ-024 Reset mid-operation SHALL abandon the transaction; no partial line install, no l1_ready.

Configuration
REQ-025 Macro L2_STATS_EN defined: hit_count/miss_count SHALL increment once per accepted request (hit/miss), saturating at 32'hFFFF_FFFF.
REQ-026 Macro L2_STATS_EN undefined: counters SHALL not exist; hit_count and miss_count tied to 0.

Structure
REQ-027 Shared package SHALL hold state encodings, line width 128, address width 28.
REQ-028 Tag/data/valid/dirty arrays SHALL be one sub-module l2_tag_data_array (read combinational, write synchronous single-port).

Verification
REQ-029 Reset, read 28'h0000040, mem_ready after 3 cycles with 128'hA5.. -> one mem_read to 28'h0000040, l1_ready once, l1_rdata=128'hA5.., miss_count=1.
REQ-030 Repeat read 28'h0000040 -> l1_ready next cycle, no mem activity, hit_count=1.
REQ-031 Write 28'h0000080 with 128'h1234 (miss), then read 28'h00000C0 (same index 0, different tag) -> mem_write addr 28'h0000080 data 128'h1234, then mem_read 28'h00000C0.
REQ-032 l1_read and l1_write both high to hitting line -> read data returned, line content unchanged.
REQ-033 proc_reset asserted during ALLOCATE -> no l1_ready, subsequent read of same address misses again.
REQ-034 Build without L2_STATS_EN, run REQ-029/030 -> hit_count=miss_count=0 throughout.
